onehot_decoder: RTL and testbench

- Parameterized binary-to-one-hot decoder.
- Converts an IN_W-bit index into an OUT_W-bit one-hot vector.
- Provides a combinational output for same-cycle use, e.g. selecting the condition type from the 2-bit flag field in the control unit.
- Also provides a registered copy with valid and out-of-range indications for pipelined consumers.

---
 rtl/onehot_decoder.sv | 90 +++++++++
 tb/tb_onehot_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder.sv
// ---------------------------------------------------------------------------
// onehot_decoder
//   Parameterized binary-to-one-hot decoder with a zero-latency combinational
//   output and a one-cycle registered copy carrying valid and out-of-range
//   indications.
//
// Parameters
//   IN_W   width of the binary index (1..8)
//   OUT_W  number of one-hot lines (1..2**IN_W)
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset (registered path only)
//   i_en       decode enable; combinational outputs are zero when low
//   i_in       binary index, unsigned
//   o_out      combinational one-hot result
//   o_oor      combinational out-of-range flag (i_in >= OUT_W while enabled)
//   o_out_q    registered one-hot result
//   o_valid_q  registered enable
//   o_oor_q    registered out-of-range flag
//
// Optional feature macro: ONEHOT_DECODER_HOLD_EN
//   When defined, edges with i_en low keep o_out_q / o_oor_q at their last
//   decode (o_valid_q still drops). When undefined they clear to zero.
// ---------------------------------------------------------------------------
module onehot_decoder #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [IN_W-1:0]  i_in,
    output logic [OUT_W-1:0] o_out,
    output logic             o_oor,
    output logic [OUT_W-1:0] o_out_q,
    output logic             o_valid_q,
    output logic             o_oor_q
);

    // Reject illegal widths at elaboration instead of truncating.
    if (IN_W < 1 || IN_W > 8) begin : g_bad_in_w
        $fatal(1, "onehot_decoder: IN_W=%0d outside 1..8", IN_W);
    end
    if (OUT_W < 1 || OUT_W > (1 << IN_W)) begin : g_bad_out_w
        $fatal(1, "onehot_decoder: OUT_W=%0d outside 1..2**IN_W", OUT_W);
    end

    logic [OUT_W-1:0] w_out;
    logic             w_oor;
    logic [OUT_W-1:0] r_out_q;
    logic             r_valid_q;
    logic             r_oor_q;

    // Each line compares against its own index, so an index >= OUT_W
    // matches no line and the vector is naturally all zeros.
    always_comb begin
        w_out = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w_out[i] = i_en && (i_in == IN_W'(i));
        end
        w_oor = i_en && (32'(i_in) >= 32'(OUT_W));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_q   <= '0;
            r_valid_q <= 1'b0;
            r_oor_q   <= 1'b0;
        end else begin
            r_valid_q <= i_en;
`ifdef ONEHOT_DECODER_HOLD_EN
            if (i_en) begin
                r_out_q <= w_out;
                r_oor_q <= w_oor;
            end
`else
            r_out_q <= w_out;
            r_oor_q <= w_oor;
`endif
        end
    end

    assign o_out     = w_out;
    assign o_oor     = w_oor;
    assign o_out_q   = r_out_q;
    assign o_valid_q = r_valid_q;
    assign o_oor_q   = r_oor_q;

endmodule

// File: tb/tb_onehot_decoder.sv
// ---------------------------------------------------------------------------
// tb_onehot_decoder
//   Directed and randomized checks of onehot_decoder with the default
//   2-to-4 configuration plus a 2-to-3 instance for out-of-range behaviour.
//   Inputs are driven 1 time unit after a rising edge; combinational outputs
//   are sampled 1 unit later, registered outputs 1 unit after the next edge.
// ---------------------------------------------------------------------------
module tb_onehot_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] in_v;

    logic [3:0] out4, out4_q;
    logic       oor4, valid4_q, oor4_q;
    logic [2:0] out3, out3_q;
    logic       oor3, valid3_q, oor3_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onehot_decoder #(.IN_W(2), .OUT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_in(in_v),
        .o_out(out4), .o_oor(oor4), .o_out_q(out4_q),
        .o_valid_q(valid4_q), .o_oor_q(oor4_q)
    );

    onehot_decoder #(.IN_W(2), .OUT_W(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_in(in_v),
        .o_out(out3), .o_oor(oor3), .o_out_q(out3_q),
        .o_valid_q(valid3_q), .o_oor_q(oor3_q)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; in_v = 2'd1;
        tick();
        checks++;
        if (out4_q !== 4'b0000 || valid4_q !== 1'b0 || oor4_q !== 1'b0) begin
            failures++;
            $display("FAIL reset4 got out_q=%b valid_q=%b oor_q=%b want 0000 0 0",
                     out4_q, valid4_q, oor4_q);
        end
        checks++;
        if (out3_q !== 3'b000 || valid3_q !== 1'b0 || oor3_q !== 1'b0) begin
            failures++;
            $display("FAIL reset3 got out_q=%b valid_q=%b oor_q=%b want 000 0 0",
                     out3_q, valid3_q, oor3_q);
        end
        // Combinational path follows inputs even while reset is held.
        #1;
        checks++;
        if (out4 !== 4'b0010) begin
            failures++;
            $display("FAIL comb_in_reset got %b want 0010", out4);
        end
        rst = 1'b0;
    endtask

    task automatic test_comb_sweep();
        logic [3:0] exp_tbl [4];
        exp_tbl[0] = 4'b0001; exp_tbl[1] = 4'b0010;
        exp_tbl[2] = 4'b0100; exp_tbl[3] = 4'b1000;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_v = 2'(i);
            #1;
            checks++;
            if (out4 !== exp_tbl[i] || oor4 !== 1'b0) begin
                failures++;
                $display("FAIL sweep in=%0d got out=%b oor=%b want %b 0",
                         i, out4, oor4, exp_tbl[i]);
            end
            tick();
        end
    endtask

    task automatic test_disable();
        en = 1'b1; in_v = 2'd3;
        tick();
        checks++;
        if (out4_q !== 4'b1000 || valid4_q !== 1'b1) begin
            failures++;
            $display("FAIL dis_pre got out_q=%b valid_q=%b want 1000 1", out4_q, valid4_q);
        end
        en = 1'b0;
        #1;
        checks++;
        if (out4 !== 4'b0000 || oor4 !== 1'b0) begin
            failures++;
            $display("FAIL dis_comb got out=%b oor=%b want 0000 0", out4, oor4);
        end
        tick();
        checks++;
`ifdef ONEHOT_DECODER_HOLD_EN
        if (out4_q !== 4'b1000 || valid4_q !== 1'b0) begin
            failures++;
            $display("FAIL dis_reg got out_q=%b valid_q=%b want 1000 0", out4_q, valid4_q);
        end
`else
        if (out4_q !== 4'b0000 || valid4_q !== 1'b0) begin
            failures++;
            $display("FAIL dis_reg got out_q=%b valid_q=%b want 0000 0", out4_q, valid4_q);
        end
`endif
    endtask

    task automatic test_latency();
        en = 1'b1; in_v = 2'd0;
        tick();
        in_v = 2'd2;
        #1;
        checks++;
        if (out4 !== 4'b0100 || out4_q !== 4'b0001) begin
            failures++;
            $display("FAIL lat_before got out=%b out_q=%b want 0100 0001", out4, out4_q);
        end
        tick();
        checks++;
        if (out4_q !== 4'b0100 || valid4_q !== 1'b1) begin
            failures++;
            $display("FAIL lat_after got out_q=%b valid_q=%b want 0100 1", out4_q, valid4_q);
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; in_v = 2'd1;
        tick();
        checks++;
        if (out4_q !== 4'b0010) begin
            failures++;
            $display("FAIL rmid_pre got out_q=%b want 0010", out4_q);
        end
        rst = 1'b1; in_v = 2'd3;
        #1;
        checks++;
        if (out4 !== 4'b1000) begin
            failures++;
            $display("FAIL rmid_comb got out=%b want 1000", out4);
        end
        tick();
        checks++;
        if (out4_q !== 4'b0000 || valid4_q !== 1'b0 || oor4_q !== 1'b0) begin
            failures++;
            $display("FAIL rmid_clr got out_q=%b valid_q=%b oor_q=%b want 0000 0 0",
                     out4_q, valid4_q, oor4_q);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (out4_q !== 4'b1000 || valid4_q !== 1'b1) begin
            failures++;
            $display("FAIL rmid_resume got out_q=%b valid_q=%b want 1000 1", out4_q, valid4_q);
        end
    endtask

    task automatic test_oor();
        en = 1'b1; in_v = 2'd3;
        #1;
        checks++;
        if (out3 !== 3'b000 || oor3 !== 1'b1) begin
            failures++;
            $display("FAIL oor_comb got out=%b oor=%b want 000 1", out3, oor3);
        end
        tick();
        checks++;
        if (out3_q !== 3'b000 || oor3_q !== 1'b1 || valid3_q !== 1'b1) begin
            failures++;
            $display("FAIL oor_reg got out_q=%b oor_q=%b valid_q=%b want 000 1 1",
                     out3_q, oor3_q, valid3_q);
        end
        in_v = 2'd2;
        #1;
        checks++;
        if (out3 !== 3'b100 || oor3 !== 1'b0) begin
            failures++;
            $display("FAIL oor_inrange got out=%b oor=%b want 100 0", out3, oor3);
        end
        tick();
        checks++;
        if (out3_q !== 3'b100 || oor3_q !== 1'b0) begin
            failures++;
            $display("FAIL oor_inrange_reg got out_q=%b oor_q=%b want 100 0", out3_q, oor3_q);
        end
        en = 1'b0; in_v = 2'd3;
        #1;
        checks++;
        if (oor3 !== 1'b0 || out3 !== 3'b000) begin
            failures++;
            $display("FAIL oor_dis got out=%b oor=%b want 000 0", out3, oor3);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] exp_out;
        logic [3:0] exp_q;
        logic       exp_v;
        logic       r;
        // Bring to a known registered state first.
        rst = 1'b1; en = 1'b0; in_v = 2'd0;
        tick();
        exp_q = 4'b0000; exp_v = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            r    = ($urandom_range(0, 49) == 0);
            rst  = r;
            en   = 1'($urandom_range(0, 3) != 0);
            in_v = 2'($urandom_range(0, 3));
            exp_out = 4'b0000;
            if (en) begin
                case (in_v)
                    2'd0: exp_out = 4'b0001;
                    2'd1: exp_out = 4'b0010;
                    2'd2: exp_out = 4'b0100;
                    default: exp_out = 4'b1000;
                endcase
            end
            #1;
            checks++;
            if (out4 !== exp_out || oor4 !== 1'b0 || $countones(out4) > 1) begin
                failures++;
                $display("FAIL rand_comb cyc=%0d got out=%b oor=%b want %b 0",
                         c, out4, oor4, exp_out);
            end
            if (r) begin
                exp_q = 4'b0000; exp_v = 1'b0;
            end else begin
                exp_v = en;
`ifdef ONEHOT_DECODER_HOLD_EN
                if (en) exp_q = exp_out;
`else
                exp_q = exp_out;
`endif
            end
            tick();
            checks++;
            if (out4_q !== exp_q || valid4_q !== exp_v || oor4_q !== 1'b0) begin
                failures++;
                $display("FAIL rand_reg cyc=%0d got out_q=%b valid_q=%b oor_q=%b want %b %b 0",
                         c, out4_q, valid4_q, oor4_q, exp_q, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_v = 2'd0;
        #1;
        test_reset();
        test_comb_sweep();
        test_disable();
        test_latency();
        test_reset_mid();
        test_oor();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
